// File: rtl/vga_pkg.sv
// Shared VGA pipeline constants and the update-scheduler state encoding.
// Both the timing generator and the scheduler import this package.
package vga_pkg;

    localparam int VGA_VER_ACTIVE = 600;
    localparam int VGA_VER_TOTAL  = 628;
    localparam int FRAME_CNT_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_GRANT,
        S_CLOSED
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after ptr,
// wrapping from the top index back to 0. Output is one-hot, or zero when nothing is pending.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic             valid
);

    // The first pass covers indices ptr..N_REQ-1; the second pass covers the wrapped part.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        pick  = '0;
        valid = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (j >= int'(ptr))) begin
                pick[j] = 1'b1;
                valid   = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j]) begin
                pick[j] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_update_sched.sv
// Grants exclusive, vblank-only access to shared frame/config state, round-robin
// among requesters. A grant ends early on timeout or when the pre-active guard band begins.
module vga_update_sched
    import vga_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int VER_ACTIVE  = VGA_VER_ACTIVE,
    parameter int VER_TOTAL   = VGA_VER_TOTAL,
    parameter int GUARD_LINES = 2,
    parameter int TIMEOUT     = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [10:0]            vcount,
    input  logic                   vblnk,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       done,
    output logic [N_REQ-1:0]       gnt,
    output logic                   abort,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   timeout_err,
    output logic [N_REQ-1:0]       starved
);

    localparam int             PW         = $clog2(N_REQ);
    localparam int             TW         = $clog2(TIMEOUT);
    localparam logic [10:0]    CLOSE_LINE = 11'(VER_TOTAL - GUARD_LINES);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0]  PTR_LAST   = PW'(N_REQ - 1);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 2 ||
        VER_ACTIVE + GUARD_LINES >= VER_TOTAL) begin : g_bad_params
        $error("vga_update_sched: inconsistent parameters");
    end

    sched_state_t     state, state_n;
    logic             vblnk_q;
    logic [PW-1:0]    ptr, ptr_n, gnt_idx, ptr_inc;
    logic [TW-1:0]    timer, timer_n;
    logic [N_REQ-1:0] gnt_n, starved_n, pick;
    logic             abort_n, toerr_n, pick_valid;
    logic             vb_rise, win_open, finished, timed_out;

    assign vb_rise   = vblnk & ~vblnk_q;
    assign win_open  = vblnk & (vcount < CLOSE_LINE);
    assign busy      = |gnt;
    // A done pulse or a dropped request from the holder is a clean finish; it outranks any abort cause.
    assign finished  = |(done & gnt) | ~|(req & gnt);
    assign timed_out = (timer == TIMER_LAST);

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
        ptr_inc = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        abort_n   = 1'b0;
        ptr_n     = ptr;
        timer_n   = timer;
        toerr_n   = timeout_err;
        starved_n = starved;
        unique case (state)
            S_IDLE: begin
                if (vb_rise) state_n = S_ARB;
            end
            S_ARB: begin
                if (!vblnk) begin
                    state_n = S_IDLE;
                end else if (!win_open) begin
                    state_n   = S_CLOSED;
                    starved_n = starved | req;
                end else if (pick_valid) begin
                    gnt_n   = pick;
                    timer_n = '0;
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (finished || timed_out || !win_open) begin
                    gnt_n   = '0;
                    ptr_n   = ptr_inc;
                    abort_n = ~finished;
                    toerr_n = timeout_err | (timed_out & ~finished);
                    state_n = vblnk ? S_ARB : S_IDLE;
                end else if (timer != TIMER_LAST) begin
                    timer_n = timer + 1'b1;
                end
            end
            S_CLOSED: begin
                if (!vblnk) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            vblnk_q     <= 1'b0;
            ptr         <= '0;
            timer       <= '0;
            gnt         <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
            starved     <= '0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_n;
            vblnk_q     <= vblnk;
            ptr         <= ptr_n;
            timer       <= timer_n;
            gnt         <= gnt_n;
            abort       <= abort_n;
            timeout_err <= toerr_n;
            starved     <= starved_n;
            if (vb_rise) frame_cnt <= frame_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_update_sched.sv
// Scoreboard bench for vga_update_sched: stimulus queues expected grant/release events,
// and a negedge monitor pops and compares them whenever gnt changes.
module tb_vga_update_sched;
    import vga_pkg::*;

    localparam int          N       = 4;
    localparam int          TO      = 16;
    localparam logic [10:0] L_VB    = 11'd600;
    localparam logic [10:0] L_CLOSE = 11'd626;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [10:0]  vcount = '0;
    logic         vblnk  = 1'b0;
    logic [N-1:0] req    = '0;
    logic [N-1:0] done   = '0;
    logic [N-1:0] gnt, starved;
    logic         abort, busy, timeout_err;
    logic [15:0]  frame_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef enum logic {EV_GNT, EV_END} ev_kind_t;
    typedef struct {
        ev_kind_t     kind;
        logic [N-1:0] val;
        int           at;
    } ev_t;
    ev_t exp_q[$];

    vga_update_sched #(
        .N_REQ       (N),
        .VER_ACTIVE  (600),
        .VER_TOTAL   (628),
        .GUARD_LINES (2),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vcount      (vcount),
        .vblnk       (vblnk),
        .req         (req),
        .done        (done),
        .gnt         (gnt),
        .abort       (abort),
        .busy        (busy),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err),
        .starved     (starved)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input ev_kind_t k, input logic [N-1:0] v, input int at);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected %s %b at cycle %0d", k.name(), v, at);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.val != v || e.at != at) begin
            errors++;
            $display("FAIL scoreboard: got %s %b @%0d, expected %s %b @%0d",
                     k.name(), v, at, e.kind.name(), e.val, e.at);
        end
    endtask

    // Monitor: an END event carries the abort flag seen on the cycle gnt falls.
    logic [N-1:0] gnt_prev = '0;
    always @(negedge clk) begin
        if (gnt !== gnt_prev) begin
            if (gnt_prev != '0) observe(EV_END, {{(N-1){1'b0}}, abort}, cyc);
            if (gnt != '0)      observe(EV_GNT, gnt, cyc);
        end else if (abort) begin
            checks++;
            errors++;
            $display("FAIL stray_abort: abort=1 at cycle %0d without a grant release", cyc);
        end
        gnt_prev = gnt;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic expect_gnt(input logic [N-1:0] v, input int at);
        exp_q.push_back('{kind: EV_GNT, val: v, at: at});
    endtask

    task automatic expect_end(input logic ab, input int at);
        exp_q.push_back('{kind: EV_END, val: {{(N-1){1'b0}}, ab}, at: at});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        vblnk  = 1'b0;
        vcount = '0;
        req    = '0;
        done   = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic start_frame(output int t);
        vcount = L_VB;
        vblnk  = 1'b1;
        t      = cyc;
    endtask

    task automatic end_frame();
        vblnk  = 1'b0;
        vcount = '0;
        tick(3);
    endtask

    // Requester side: hold the grant for `hold` cycles, then pulse done and drop req together.
    task automatic serve(input logic [N-1:0] v, input int g, input int hold);
        expect_gnt(v, g);
        wait_until(g);
        if (hold > 1) tick(hold - 1);
        done = v;
        req  = req & ~v;
        expect_end(1'b0, cyc + 1);
        tick(1);
        done = '0;
    endtask

    initial begin
        int t, g;

        // Reset state
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_abort", abort, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_starved", starved, 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // 1: single request, grant two cycles after vblank rise, clean done
        req = 4'b0010;
        start_frame(t);
        serve(4'b0010, t + 2, 1);
        check("t1_abort", abort, 0);
        end_frame();
        check("t1_frame_cnt", frame_cnt, 1);

        // 2: round-robin over all four, one idle cycle between grants
        do_reset();
        req = 4'b1111;
        start_frame(t);
        g = t + 2;
        for (int i = 0; i < N; i++) begin
            serve(4'(1 << i), g, 10);
            g = g + 11;
        end
        end_frame();
        req = 4'b1111;
        start_frame(t);
        serve(4'b0001, t + 2, 10);
        req = '0;
        end_frame();
        check("t2_frame_cnt", frame_cnt, 2);

        // 3: timeout after TO cycles of holding
        do_reset();
        req = 4'b0100;
        start_frame(t);
        g = t + 2;
        expect_gnt(4'b0100, g);
        expect_end(1'b1, g + TO);
        wait_until(g);
        check("t3_busy", busy, 1);
        wait_until(g + TO);
        req = '0;
        check("t3_abort", abort, 1);
        check("t3_timeout_err", timeout_err, 1);
        tick(1);
        check("t3_abort_pulse", abort, 0);
        end_frame();
        check("t3_timeout_sticky", timeout_err, 1);

        // 4: window closes mid-grant, pending requester marked starved
        do_reset();
        req = 4'b1001;
        start_frame(t);
        g = t + 2;
        expect_gnt(4'b0001, g);
        wait_until(g + 3);
        vcount = L_CLOSE;
        expect_end(1'b1, cyc + 1);
        tick(1);
        req = 4'b1000;
        tick(2);
        check("t4_starved", starved, 4'b1000);
        check("t4_gnt", gnt, 0);
        check("t4_timeout_err", timeout_err, 0);
        req = '0;
        end_frame();
        check("t4_starved_sticky", starved, 4'b1000);

        // 5a: done coincides with window close -> no abort
        do_reset();
        req = 4'b0010;
        start_frame(t);
        expect_gnt(4'b0010, t + 2);
        wait_until(t + 4);
        vcount = L_CLOSE;
        done   = 4'b0010;
        req    = '0;
        expect_end(1'b0, cyc + 1);
        tick(1);
        done = '0;
        check("t5_abort", abort, 0);
        tick(2);
        check("t5_starved", starved, 0);
        end_frame();

        // 5b: vblank falls mid-grant -> release with abort
        req = 4'b0001;
        start_frame(t);
        expect_gnt(4'b0001, t + 2);
        wait_until(t + 5);
        expect_end(1'b1, cyc + 1);
        vblnk  = 1'b0;
        vcount = '0;
        tick(1);
        req = '0;
        check("t5_vbfall_gnt", gnt, 0);
        check("t5_vbfall_abort", abort, 1);
        tick(2);
        check("t5_frame_cnt", frame_cnt, 2);

        // 5c: asynchronous reset mid-grant
        req = 4'b0100;
        start_frame(t);
        expect_gnt(4'b0100, t + 2);
        wait_until(t + 4);
        check("t5_pre_rst_frame_cnt", frame_cnt, 3);
        expect_end(1'b0, cyc);
        rst_n = 1'b0;
        #1;
        check("t5_rst_gnt", gnt, 0);
        check("t5_rst_frame_cnt", frame_cnt, 0);
        check("t5_rst_abort", abort, 0);
        check("t5_rst_busy", busy, 0);
        req    = '0;
        vblnk  = 1'b0;
        vcount = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // 6: done on a non-granted bit is ignored
        req = 4'b0001;
        start_frame(t);
        expect_gnt(4'b0001, t + 2);
        wait_until(t + 3);
        done = 4'b0100;
        tick(1);
        done = '0;
        tick(1);
        check("t6_gnt_kept", gnt, 4'b0001);
        check("t6_busy", busy, 1);
        done = 4'b0001;
        req  = '0;
        expect_end(1'b0, cyc + 1);
        tick(1);
        done = '0;
        end_frame();
        check("t6_frame_cnt", frame_cnt, 1);

        // 6: frame counter wrap
        force dut.frame_cnt = 16'hFFFF;
        tick(1);
        release dut.frame_cnt;
        tick(1);
        check("t6_frame_cnt_preset", frame_cnt, 16'hFFFF);
        start_frame(t);
        tick(1);
        check("t6_frame_cnt_wrap", frame_cnt, 0);
        end_frame();

        tick(5);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
